// File: rtl/turbo_itl_pkg.sv
// Shared types and constants for the HomePlug Green PHY turbo bit-pair interleaver.
// The size table maps each pb_size code to block length L, step S and offset O.
package turbo_itl_pkg;

    localparam int unsigned MAX_PAIRS = 2080;
    localparam int unsigned AW        = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    typedef struct packed {
        logic [AW-1:0] len;
        logic [AW-1:0] step;
        logic [AW-1:0] ofs;
    } size_cfg_t;

    function automatic size_cfg_t size_cfg(input logic [1:0] code);
        size_cfg_t c;
        case (code)
            2'd0:    c = '{len: 12'd64,   step: 12'd37, ofs: 12'd11};
            2'd1:    c = '{len: 12'd544,  step: 12'd37, ofs: 12'd11};
            2'd2:    c = '{len: 12'd2080, step: 12'd37, ofs: 12'd11};
            default: c = '{len: 12'd8,    step: 12'd5,  ofs: 12'd3};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pair_ram.sv
// Bit-pair buffer: one write port and two independent synchronous read ports.
// Contents are deliberately not reset.
module pair_ram #(
    parameter int unsigned DEPTH = 2080,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [1:0]    rdata_a,
    output logic [1:0]    rdata_b
);

    logic [1:0] mem [DEPTH];
    logic [1:0] rdata_a_q;
    logic [1:0] rdata_b_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a_q <= mem[raddr_a];
        rdata_b_q <= mem[raddr_b];
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/turbo_interleaver_top.sv
// Turbo bit-pair interleaver: captures one PB, then streams it in natural and
// interleaved order in parallel. I(k) = (S*k + O) mod L is built incrementally.
module turbo_interleaver_top #(
    parameter int unsigned MAX_PAIRS = 2080,
    parameter int unsigned AW        = 12
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] pb_size,
    input  logic [1:0] din,
    input  logic       din_vld,
    output logic [1:0] rdata,
    output logic [1:0] rdata_itl,
    output logic       dout_vld
);

    import turbo_itl_pkg::*;

    state_e        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [AW-1:0] itl_q, itl_d;
    logic          issued_q, issued_d;
    logic [1:0]    rdata_q, rdata_d;
    logic [1:0]    rdata_itl_q, rdata_itl_d;
    logic          dout_vld_q, dout_vld_d;

    size_cfg_t     cfg;
    logic [AW:0]   itl_sum;
    logic          we;
    logic [AW-1:0] waddr;
    logic [1:0]    ram_a;
    logic [1:0]    ram_b;

    always_comb begin
        cfg         = size_cfg(size_q);
        state_d     = state_q;
        size_d      = size_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        itl_d       = itl_q;
        issued_d    = 1'b0;
        we          = 1'b0;
        waddr       = wcnt_q;
        // RAM data issued on the previous edge is registered here, so the
        // output stage lags the issue edge by exactly one cycle.
        rdata_d     = issued_q ? ram_a : '0;
        rdata_itl_d = issued_q ? ram_b : '0;
        dout_vld_d  = issued_q;

        itl_sum = {1'b0, itl_q} + {1'b0, cfg.step};
        if (itl_sum >= {1'b0, cfg.len}) begin
            itl_sum = itl_sum - {1'b0, cfg.len};
        end

        case (state_q)
            IDLE: begin
                if (din_vld) begin
                    size_d  = pb_size;
                    we      = 1'b1;
                    waddr   = '0;
                    wcnt_d  = {{(AW-1){1'b0}}, 1'b1};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                we = 1'b1;
                if (wcnt_q == cfg.len - 1'b1) begin
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    itl_d   = cfg.ofs;
                    state_d = READ;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            READ: begin
                issued_d = 1'b1;
                if (rcnt_q == cfg.len - 1'b1) begin
                    rcnt_d  = '0;
                    itl_d   = '0;
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                    itl_d  = itl_sum[AW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            size_q      <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            itl_q       <= '0;
            issued_q    <= 1'b0;
            rdata_q     <= '0;
            rdata_itl_q <= '0;
            dout_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            itl_q       <= itl_d;
            issued_q    <= issued_d;
            rdata_q     <= rdata_d;
            rdata_itl_q <= rdata_itl_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    pair_ram #(
        .DEPTH (MAX_PAIRS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (we && n_rst),
        .waddr   (waddr),
        .wdata   (din),
        .raddr_a (rcnt_q),
        .raddr_b (itl_q),
        .rdata_a (ram_a),
        .rdata_b (ram_b)
    );

    assign rdata     = rdata_q;
    assign rdata_itl = rdata_itl_q;
    assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_turbo_interleaver_top.sv
// Scoreboard bench for turbo_interleaver_top: stimulus pushes expected pairs
// (with their expected output cycle), an independent monitor pops and compares.
module tb_turbo_interleaver_top;

    logic       clk;
    logic       n_rst;
    logic [1:0] pb_size;
    logic [1:0] din;
    logic       din_vld;
    logic [1:0] rdata;
    logic [1:0] rdata_itl;
    logic       dout_vld;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] itl;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] blk [2080];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    turbo_interleaver_top #(
        .MAX_PAIRS (2080),
        .AW        (12)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pb_size   (pb_size),
        .din       (din),
        .din_vld   (din_vld),
        .rdata     (rdata),
        .rdata_itl (rdata_itl),
        .dout_vld  (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int blk_len(input logic [1:0] code);
        case (code)
            2'd0:    return 64;
            2'd1:    return 544;
            2'd2:    return 2080;
            default: return 8;
        endcase
    endfunction

    function automatic int blk_step(input logic [1:0] code);
        return (code == 2'd3) ? 5 : 37;
    endfunction

    function automatic int blk_ofs(input logic [1:0] code);
        return (code == 2'd3) ? 3 : 11;
    endfunction

    // Direct modulo form of the map, independent of the incremental generator.
    task automatic push_model(input logic [1:0] code, input int e0);
        int   n;
        exp_t e;
        n = blk_len(code);
        for (int k = 0; k < n; k++) begin
            e.rd  = blk[k];
            e.itl = blk[(blk_step(code) * k + blk_ofs(code)) % n];
            e.cyc = e0 + n + 1 + k;
            sb.push_back(e);
        end
    endtask

    // Short block: input 00,01,10,01,10,01,10,01 with hand-derived outputs.
    task automatic load_short();
        logic [1:0] pat [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 8; i++) blk[i] = pat[i];
    endtask

    task automatic push_short(input int e0);
        logic [1:0] rd_t  [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        logic [1:0] itl_t [8] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.rd  = rd_t[k];
            e.itl = itl_t[k];
            e.cyc = e0 + 9 + k;
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; the next posedge is the strobe edge.
    task automatic send_block(input logic [1:0] code, input bit pulse);
        int n;
        n       = blk_len(code);
        pb_size = code;
        din     = blk[0];
        din_vld = 1'b1;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            pb_size = ~code;
            din     = blk[i];
            din_vld = pulse && (i % 2 == 1);
        end
        @(negedge clk);
        din_vld = 1'b0;
        din     = '0;
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic drain(input int budget);
        int guard = 0;
        while (sb.size() != 0 && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (dout_vld !== 1'b0 || rdata !== 2'b00 || rdata_itl !== 2'b00) begin
            errors++;
            $display("FAIL %s dout_vld=%b rdata=%b rdata_itl=%b required 0/00/00",
                     name, dout_vld, rdata, rdata_itl);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                checks++;
                if (dout_vld === 1'b1) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out rdata=%b rdata_itl=%b cyc=%0d required no output",
                                 rdata, rdata_itl, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (rdata !== e.rd || rdata_itl !== e.itl || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL out_pair rdata=%b rdata_itl=%b cyc=%0d required rdata=%b rdata_itl=%b cyc=%0d",
                                     rdata, rdata_itl, cyc, e.rd, e.itl, e.cyc);
                        end
                    end
                end else if (dout_vld !== 1'b0 || rdata !== 2'b00 || rdata_itl !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_outputs dout_vld=%b rdata=%b rdata_itl=%b cyc=%0d required 0/00/00",
                             dout_vld, rdata, rdata_itl, cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e0;
        n_rst   = 1'b0;
        pb_size = 2'd0;
        din     = 2'd0;
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        n_rst  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Short block with hand-computed outputs
        load_short();
        e0 = cyc + 1;
        push_short(e0);
        send_block(2'd3, 1'b0);
        drain(100);

        // 64-pair block, pair k = k mod 4
        for (int i = 0; i < 64; i++) blk[i] = 2'(i % 4);
        e0 = cyc + 1;
        push_model(2'd0, e0);
        send_block(2'd0, 1'b0);
        drain(300);

        // 64-pair block, random pairs (exposes any address permutation error)
        for (int i = 0; i < 64; i++) blk[i] = 2'($urandom_range(0, 3));
        e0 = cyc + 1;
        push_model(2'd0, e0);
        send_block(2'd0, 1'b0);
        drain(300);

        // Largest block: wrap arithmetic across all 2080 steps
        for (int i = 0; i < 2080; i++) blk[i] = 2'($urandom_range(0, 3));
        e0 = cyc + 1;
        push_model(2'd2, e0);
        send_block(2'd2, 1'b0);
        drain(5000);

        // Stray din_vld pulses in WRITE and READ must be ignored
        load_short();
        e0 = cyc + 1;
        push_short(e0);
        send_block(2'd3, 1'b1);
        pb_size = 2'd2;
        for (int i = 0; i < 3; i++) begin
            din_vld = 1'b1;
            @(negedge clk);
            din_vld = 1'b0;
            @(negedge clk);
        end
        drain(100);

        // Reset mid-READ aborts the block; a fresh block follows cleanly
        load_short();
        e0 = cyc + 1;
        push_short(e0);
        send_block(2'd3, 1'b0);
        wait_cyc(e0 + 11);
        n_rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_idle("reset_abort");
        n_rst = 1'b1;
        repeat (12) @(negedge clk);
        e0 = cyc + 1;
        push_short(e0);
        send_block(2'd3, 1'b0);
        drain(100);

        // Back-to-back: second strobe while the last pair of the first is shown
        load_short();
        e0 = cyc + 1;
        push_short(e0);
        send_block(2'd3, 1'b0);
        wait_cyc(e0 + 16);
        for (int i = 0; i < 64; i++) blk[i] = 2'($urandom_range(0, 3));
        e0 = cyc + 1;
        push_model(2'd0, e0);
        send_block(2'd0, 1'b0);
        drain(300);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
